// File: rtl/wb_writer_pkg.sv
// rtl/wb_writer_pkg.sv - shared load-type codes, reset PC and W-register layout
//
// Purpose: definitions shared by the write-back stage and its load aligner.
//   LT_*             3-bit load-type codes carried down the pipe with a load
//   DEFAULT_RESET_PC value the trace PC takes after reset
//   w_reg_t          contents of the M->W pipeline register
package wb_writer_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        regwrite;
    logic        memtoreg;
    logic [2:0]  loadtype;
    logic [31:0] aluout;
    logic [4:0]  writereg;
  } w_reg_t;

endpackage

// File: rtl/wb_writer_load_align.sv
// rtl/wb_writer_load_align.sv - combinational load data alignment and extension
//
// Purpose: selects the addressed byte/halfword of a 32-bit SRAM word and
// sign- or zero-extends it according to the load type.
// Ports:
//   rdata    in  32  raw word from the data SRAM (or its hold copy)
//   off      in  2   byte offset within the word (address bits [1:0])
//   loadtype in  3   LT_* code
//   result   out 32  aligned, extended load value; 0 for unknown load types
module wb_writer_load_align
  import wb_writer_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  loadtype,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    case (loadtype)
      LT_LW:   result = rdata;
      LT_LH:   result = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  result = {16'h0000, half_sel};
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result = {24'h000000, byte_sel};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - write-back stage: M->W register, regfile write port, trace
//
// Purpose: holds the instruction in W, aligns load data that the synchronous
// SRAM returns in the first W cycle, keeps that data across W stalls, drives
// the regfile write port and forwarding result, and emits one debug trace
// record per committed instruction.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   stallW, flushW              hold W / load a bubble (flush wins)
//   validM..writeregM           M-stage instruction fields
//   data_rdata                  SRAM read data, valid in the first W cycle only
//   we3, wa3, wd3               regfile write port
//   resultW, writeregW          forwarding value and destination (0 = no write)
//   debug_wb_*                  trace port (tied to 0 when TRACE_EN = 0)
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TRACE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallW,
  input  logic        flushW,
  input  logic        validM,
  input  logic [31:0] pcM,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic [2:0]  loadtypeM,
  input  logic [31:0] aluoutM,
  input  logic [4:0]  writeregM,
  input  logic [31:0] data_rdata,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] resultW,
  output logic [4:0]  writeregW,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  w_reg_t      w_q, w_d;
  logic        fresh_q, fresh_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [4:0]  trace_wnum_q, trace_wnum_d;
  logic [31:0] trace_wdata_q, trace_wdata_d;

  logic [31:0] load_rdata;
  logic [31:0] aligned;
  logic [31:0] result;
  logic        wr_en;
  logic        trace_fire;

  // SRAM data is only present in the first W cycle; afterwards the copy
  // captured on that cycle's edge stands in for it.
  assign load_rdata = fresh_q ? data_rdata : rdata_hold_q;

  wb_writer_load_align u_load_align (
    .rdata    (load_rdata),
    .off      (w_q.aluout[1:0]),
    .loadtype (w_q.loadtype),
    .result   (aligned)
  );

  assign result     = w_q.memtoreg ? aligned : w_q.aluout;
  assign wr_en      = w_q.valid & w_q.regwrite & (w_q.writereg != 5'd0);
  // A stalled instruction stays in W, so firing only when not stalled gives
  // exactly one record per instruction.
  assign trace_fire = w_q.valid & ~stallW;

  always_comb begin
    w_d = w_q;
    if (flushW) begin
      w_d = '0;
    end else if (!stallW) begin
      w_d.valid    = validM;
      w_d.pc       = pcM;
      w_d.regwrite = regwriteM;
      w_d.memtoreg = memtoregM;
      w_d.loadtype = loadtypeM;
      w_d.aluout   = aluoutM;
      w_d.writereg = writeregM;
    end
    fresh_d      = ~flushW & ~stallW;
    rdata_hold_d = fresh_q ? data_rdata : rdata_hold_q;

    trace_pc_d    = trace_pc_q;
    trace_wnum_d  = trace_wnum_q;
    trace_wdata_d = trace_wdata_q;
    if (trace_fire) begin
      trace_pc_d    = w_q.pc;
      trace_wnum_d  = w_q.writereg;
      trace_wdata_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q           <= '0;
      fresh_q       <= 1'b0;
      rdata_hold_q  <= 32'h0;
      trace_pc_q    <= RESET_PC;
      trace_wnum_q  <= 5'd0;
      trace_wdata_q <= 32'h0;
    end else begin
      w_q           <= w_d;
      fresh_q       <= fresh_d;
      rdata_hold_q  <= rdata_hold_d;
      trace_pc_q    <= trace_pc_d;
      trace_wnum_q  <= trace_wnum_d;
      trace_wdata_q <= trace_wdata_d;
    end
  end

  assign we3       = wr_en;
  assign wa3       = w_q.writereg;
  assign wd3       = result;
  assign resultW   = result;
  assign writeregW = wr_en ? w_q.writereg : 5'd0;

  assign debug_wb_pc       = (TRACE_EN != 0) ? trace_pc_d : 32'h0;
  assign debug_wb_rf_wen   = ((TRACE_EN != 0) && trace_fire && wr_en) ? 4'hF : 4'h0;
  assign debug_wb_rf_wnum  = (TRACE_EN != 0) ? trace_wnum_d : 5'd0;
  assign debug_wb_rf_wdata = (TRACE_EN != 0) ? trace_wdata_d : 32'h0;

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - self-checking bench for wb_writer
module tb_wb_writer;
  import wb_writer_pkg::*;

  logic        clk;
  logic        rst;
  logic        stallW, flushW, validM, regwriteM, memtoregM;
  logic [31:0] pcM, aluoutM, data_rdata;
  logic [2:0]  loadtypeM;
  logic [4:0]  writeregM;
  logic        we3;
  logic [4:0]  wa3, writeregW, debug_wb_rf_wnum;
  logic [31:0] wd3, resultW, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  wb_writer dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
    .pcM(pcM), .regwriteM(regwriteM), .memtoregM(memtoregM), .loadtypeM(loadtypeM),
    .aluoutM(aluoutM), .writeregM(writeregM), .data_rdata(data_rdata),
    .we3(we3), .wa3(wa3), .wd3(wd3), .resultW(resultW), .writeregW(writeregW),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * int'(off));
    case (lt)
      LT_LW:   return d;
      LT_LB:   return {{24{sh[7]}}, sh[7:0]};
      LT_LBU:  return {24'h0, sh[7:0]};
      LT_LH:   return {{16{sh[15]}}, sh[15:0]};
      LT_LHU:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_m(input logic [31:0] pc, input logic rw, input logic mtr,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [4:0] wr);
    exp_t e;
    validM = 1'b1; pcM = pc; regwriteM = rw; memtoregM = mtr;
    loadtypeM = lt; aluoutM = alu; writeregM = wr;
    e.we  = rw && (wr != 5'd0);
    e.wa  = wr;
    e.wd  = 32'h0;
    e.wen = e.we ? 4'hF : 4'h0;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic set_exp_wd(input logic [31:0] wd);
    exp_t e;
    e = sb.pop_back();
    e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic clear_m();
    validM = 1'b0; regwriteM = 1'b0; memtoregM = 1'b0;
  endtask

  task automatic check_record(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_we3"}, 32'(we3), 32'(e.we));
    chk({tag, "_wa3"}, 32'(wa3), 32'(e.wa));
    chk({tag, "_wd3"}, wd3, e.wd);
    chk({tag, "_resultW"}, resultW, e.wd);
    chk({tag, "_writeregW"}, 32'(writeregW), e.we ? 32'(e.wa) : 32'h0);
    chk({tag, "_wen"}, 32'(debug_wb_rf_wen), 32'(e.wen));
    chk({tag, "_dbg_pc"}, debug_wb_pc, e.pc);
    if (e.we) begin
      chk({tag, "_dbg_wnum"}, 32'(debug_wb_rf_wnum), 32'(e.wa));
      chk({tag, "_dbg_wdata"}, debug_wb_rf_wdata, e.wd);
    end
  endtask

  // Called at a negedge: M fields enter W on the next posedge; SRAM data
  // appears just after that edge; outputs are checked at the following negedge.
  task automatic issue(input string tag, input logic [31:0] pc, input logic rw, input logic mtr,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [31:0] rdata, input logic [31:0] exp_wd);
    drive_m(pc, rw, mtr, lt, alu, wr);
    set_exp_wd(exp_wd);
    @(posedge clk);
    #1;
    clear_m();
    data_rdata = rdata;
    @(negedge clk);
    check_record(tag);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  off;
    logic [2:0]  lt;
    int          rec;
    logic [2:0]  lts[4];
    lts[0] = LT_LB; lts[1] = LT_LBU; lts[2] = LT_LH; lts[3] = LT_LHU;

    rst = 1'b1; stallW = 1'b0; flushW = 1'b0; clear_m();
    pcM = 32'h0; loadtypeM = 3'd0; aluoutM = 32'h0; writeregM = 5'd0; data_rdata = 32'h0;
    #1 rst = 1'b0;
    #2;
    chk("rst_we3", 32'(we3), 32'h0);
    chk("rst_wa3", 32'(wa3), 32'h0);
    chk("rst_wd3", wd3, 32'h0);
    chk("rst_writeregW", 32'(writeregW), 32'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    issue("alu", 32'h0000_1000, 1'b1, 1'b0, LT_LW, 32'h1234_5678, 5'd8, 32'h0, 32'h1234_5678);
    issue("lb",  32'h0000_1004, 1'b1, 1'b1, LT_LB,  32'h0000_0203, 5'd3, 32'h80FF_0011, 32'hFFFF_FF80);
    issue("lbu", 32'h0000_1008, 1'b1, 1'b1, LT_LBU, 32'h0000_0203, 5'd4, 32'h80FF_0011, 32'h0000_0080);
    issue("lh",  32'h0000_100C, 1'b1, 1'b1, LT_LH,  32'h0000_0202, 5'd5, 32'h8001_7FFF, 32'hFFFF_8001);
    issue("lhu", 32'h0000_1010, 1'b1, 1'b1, LT_LHU, 32'h0000_0202, 5'd6, 32'h8001_7FFF, 32'h0000_8001);
    issue("lw",  32'h0000_1014, 1'b1, 1'b1, LT_LW,  32'h0000_0400, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D);
    issue("lt_undef", 32'h0000_1018, 1'b1, 1'b1, 3'd7, 32'h0000_0400, 5'd2, 32'hFFFF_FFFF, 32'h0);

    for (int i = 0; i < 6; i++) begin
      rd  = $urandom;
      lt  = lts[$urandom_range(0, 3)];
      off = 2'($urandom_range(0, 3));
      if (lt == LT_LH || lt == LT_LHU) off[0] = 1'b0;
      issue("rand_load", 32'h0000_2000 + 32'(4 * i), 1'b1, 1'b1, lt, {30'h40, off},
            5'(i + 10), rd, model_load(lt, off, rd));
    end

    // Idle cycle: trace PC keeps the last record's PC, no write strobe.
    @(negedge clk);
    chk("idle_dbg_pc", debug_wb_pc, 32'h0000_2014);
    chk("idle_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("idle_we3", 32'(we3), 32'h0);

    // Write to $0 is suppressed.
    issue("zero_reg", 32'h0000_3000, 1'b1, 1'b0, LT_LW, 32'h5555_AAAA, 5'd0, 32'h0, 32'h5555_AAAA);

    // LW held across a 3-cycle stall while the SRAM output goes to 0.
    drive_m(32'h0000_4000, 1'b1, 1'b1, LT_LW, 32'h0000_0100, 5'd7);
    set_exp_wd(32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    clear_m();
    stallW = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    rec = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wd3", wd3, 32'hDEAD_BEEF);
      chk("stall_wen", 32'(debug_wb_rf_wen), 32'h0);
      if (debug_wb_rf_wen == 4'hF) rec++;
      @(posedge clk);
      #1;
      data_rdata = 32'h0;
      if (i == 2) stallW = 1'b0;
    end
    @(negedge clk);
    if (debug_wb_rf_wen == 4'hF) rec++;
    check_record("stall_release");
    @(posedge clk);
    #1;
    @(negedge clk);
    if (debug_wb_rf_wen == 4'hF) rec++;
    chk("stall_record_count", 32'(rec), 32'd1);

    // Flush together with stall on a valid W instruction gives a bubble.
    issue("pre_flush", 32'h0000_5000, 1'b1, 1'b0, LT_LW, 32'h0000_0ABC, 5'd9, 32'h0, 32'h0000_0ABC);
    pcM = 32'h0000_5004; validM = 1'b1; regwriteM = 1'b1; aluoutM = 32'h0000_0DEF; writeregM = 5'd10;
    stallW = 1'b1; flushW = 1'b1;
    @(posedge clk);
    #1;
    clear_m();
    stallW = 1'b0; flushW = 1'b0;
    @(negedge clk);
    chk("flush_we3", 32'(we3), 32'h0);
    chk("flush_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("flush_writeregW", 32'(writeregW), 32'h0);

    // Asynchronous reset in the middle of a load stall.
    drive_m(32'h0000_6000, 1'b1, 1'b1, LT_LW, 32'h0000_0200, 5'd12);
    set_exp_wd(32'h1111_2222);
    @(posedge clk);
    #1;
    clear_m();
    stallW = 1'b1;
    data_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rstmid_pre_wd3", wd3, 32'h1111_2222);
    chk("rstmid_pre_we3", 32'(we3), 32'h1);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    data_rdata = 32'h0;
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_we3", 32'(we3), 32'h0);
    chk("rstmid_wa3", 32'(wa3), 32'h0);
    chk("rstmid_wd3", wd3, 32'h0);
    chk("rstmid_resultW", resultW, 32'h0);
    chk("rstmid_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
    chk("rstmid_wen", 32'(debug_wb_rf_wen), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    stallW = 1'b0;
    @(negedge clk);
    chk("rstmid_after_we3", 32'(we3), 32'h0);
    chk("rstmid_after_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("rstmid_after_wd3", wd3, 32'h0);
    chk("rstmid_after_dbg_pc", debug_wb_pc, 32'hBFC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
